counter_reader: RTL and testbench



---
 rtl/counter_reader.sv | 149 ++++++++++++++
 tb/tb_counter_reader.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/counter_reader.sv
// rtl/counter_reader.sv - sweeps the pop-counter channels and publishes sum, max and timeout map.
// Optional COUNTER_READER_SNAPSHOT_EN adds a per-channel snapshot output.
module counter_reader #(
    parameter int NUM_CH  = 5,
    parameter int TIMEOUT = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              valid,
    input  logic [4:0]        data_out,
    output logic [2:0]        idx,
    output logic              busy,
    output logic              done,
    output logic [7:0]        total,
    output logic [4:0]        max_cnt,
    output logic [2:0]        max_idx,
    output logic [NUM_CH-1:0] err
`ifdef COUNTER_READER_SNAPSHOT_EN
    ,
    output logic [5*NUM_CH-1:0] snapshot
`endif
);

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

    localparam int              WW        = $clog2(TIMEOUT + 1);
    localparam logic [2:0]      LAST_CH   = 3'(NUM_CH - 1);
    localparam logic [WW-1:0]   WAIT_LAST = WW'(TIMEOUT - 1);

    state_t             state, state_nxt;
    logic [WW-1:0]      wait_cnt;
    logic [7:0]         sum_acc, sum_nxt;
    logic [4:0]         max_acc, max_nxt;
    logic [2:0]         maxi_acc, maxi_nxt;
    logic [NUM_CH-1:0]  err_acc, err_nxt;
    logic               capture, timed_out, advance, last_ch;

`ifdef COUNTER_READER_SNAPSHOT_EN
    logic [5*NUM_CH-1:0] snap_acc, snap_nxt;
`endif

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req) state_nxt = SETTLE;
            SETTLE:  state_nxt = SAMPLE;
            SAMPLE:  if (advance) state_nxt = last_ch ? DONE : SETTLE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == SETTLE) || (state == SAMPLE);
        done = (state == DONE);
    end

    // A channel is retired either by a valid sample or by its wait window expiring.
    always_comb begin
        capture   = (state == SAMPLE) && valid;
        timed_out = (state == SAMPLE) && !valid && (wait_cnt == WAIT_LAST);
        advance   = capture || timed_out;
        last_ch   = (idx == LAST_CH);

        sum_nxt  = sum_acc + (capture ? {3'b000, data_out} : 8'd0);
        max_nxt  = max_acc;
        maxi_nxt = maxi_acc;
        if (capture && (data_out > max_acc)) begin
            max_nxt  = data_out;
            maxi_nxt = idx;
        end

        err_nxt = err_acc;
        for (int k = 0; k < NUM_CH; k++) begin
            if (timed_out && (idx == 3'(k))) err_nxt[k] = 1'b1;
        end
    end

`ifdef COUNTER_READER_SNAPSHOT_EN
    always_comb begin
        snap_nxt = snap_acc;
        for (int k = 0; k < NUM_CH; k++) begin
            if (advance && (idx == 3'(k))) snap_nxt[5*k +: 5] = capture ? data_out : 5'd0;
        end
    end
`endif

    // Results are published on the edge that retires the last channel,
    // so they are already visible during the DONE cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx      <= 3'd0;
            wait_cnt <= '0;
            sum_acc  <= 8'd0;
            max_acc  <= 5'd0;
            maxi_acc <= 3'd0;
            err_acc  <= '0;
            total    <= 8'd0;
            max_cnt  <= 5'd0;
            max_idx  <= 3'd0;
            err      <= '0;
`ifdef COUNTER_READER_SNAPSHOT_EN
            snap_acc <= '0;
            snapshot <= '0;
`endif
        end else if ((state == IDLE) && req) begin
            idx      <= 3'd0;
            wait_cnt <= '0;
            sum_acc  <= 8'd0;
            max_acc  <= 5'd0;
            maxi_acc <= 3'd0;
            err_acc  <= '0;
`ifdef COUNTER_READER_SNAPSHOT_EN
            snap_acc <= '0;
`endif
        end else if (state == SAMPLE) begin
            if (advance) begin
                wait_cnt <= '0;
                sum_acc  <= sum_nxt;
                max_acc  <= max_nxt;
                maxi_acc <= maxi_nxt;
                err_acc  <= err_nxt;
`ifdef COUNTER_READER_SNAPSHOT_EN
                snap_acc <= snap_nxt;
`endif
                if (last_ch) begin
                    total    <= sum_nxt;
                    max_cnt  <= max_nxt;
                    max_idx  <= maxi_nxt;
                    err      <= err_nxt;
`ifdef COUNTER_READER_SNAPSHOT_EN
                    snapshot <= snap_nxt;
`endif
                end else begin
                    idx <= idx + 3'd1;
                end
            end else begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_counter_reader.sv
// tb/tb_counter_reader.sv - scoreboard bench for counter_reader with directed sweeps.
module tb_counter_reader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic        valid = 1'b0;
    logic [4:0]  data_out = 5'd0;
    logic [2:0]  idx;
    logic        busy, done;
    logic [7:0]  total;
    logic [4:0]  max_cnt;
    logic [2:0]  max_idx;
    logic [4:0]  err;
`ifdef COUNTER_READER_SNAPSHOT_EN
    logic [24:0] snapshot;
`endif

    counter_reader #(.NUM_CH(5), .TIMEOUT(7)) dut (
        .clk(clk), .reset(reset), .req(req), .valid(valid), .data_out(data_out),
        .idx(idx), .busy(busy), .done(done), .total(total), .max_cnt(max_cnt),
        .max_idx(max_idx), .err(err)
`ifdef COUNTER_READER_SNAPSHOT_EN
        , .snapshot(snapshot)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  total;
        logic [4:0]  mx;
        logic [2:0]  mi;
        logic [4:0]  err;
        logic [24:0] snap;
        int          cyc;
    } exp_t;

    exp_t        sbq[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    logic [4:0]  cnt_tab [0:7];
    logic [7:0]  to_mask = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Upstream counter stage model: presents the table entry for the selected channel.
    initial begin
        for (int i = 0; i < 8; i++) cnt_tab[i] = 5'd0;
        forever begin
            @(negedge clk);
            data_out = cnt_tab[idx];
            valid    = !to_mask[idx];
        end
    end

    // Monitor: every done pulse consumes one scoreboard entry.
    always @(negedge clk) begin
        if (!reset && done === 1'b1) begin
            if (sbq.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d expected no pulse", cyc);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("done_cycle", cyc, e.cyc);
                chk("total", total, e.total);
                chk("max_cnt", max_cnt, e.mx);
                chk("max_idx", max_idx, e.mi);
                chk("err", err, e.err);
`ifdef COUNTER_READER_SNAPSHOT_EN
                chk("snapshot", snapshot, e.snap);
`endif
            end
        end
    end

    task automatic load(input int a, b, c, d, f, input logic [7:0] m);
        cnt_tab[0] = 5'(a); cnt_tab[1] = 5'(b); cnt_tab[2] = 5'(c);
        cnt_tab[3] = 5'(d); cnt_tab[4] = 5'(f);
        to_mask = m;
    endtask

    task automatic push_exp(input int start, input int et, em, ei);
        exp_t e;
        int   n = 0;
        e.total = 8'(et);
        e.mx    = 5'(em);
        e.mi    = 3'(ei);
        e.err   = to_mask[4:0];
        e.snap  = '0;
        for (int k = 0; k < 5; k++) begin
            if (to_mask[k]) n++;
            else e.snap[5*k +: 5] = cnt_tab[k];
        end
        e.cyc = start + 10 + 6 * n;
        sbq.push_back(e);
    endtask

    task automatic sweep(input int a, b, c, d, f, input logic [7:0] m,
                         input int et, em, ei, input bit expect_done);
        int st;
        @(negedge clk);
        load(a, b, c, d, f, m);
        req = 1'b1;
        st  = cyc + 1;
        if (expect_done) push_exp(st, et, em, ei);
        @(negedge clk);
        req = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sbq.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sbq.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: got %0d pending results expected 0", sbq.size());
            sbq.delete();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int st, n;
        repeat (3) @(negedge clk);
        chk("rst_idx", idx, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_total", total, 0);
        chk("rst_max", {max_idx, max_cnt}, 0);
        chk("rst_err", err, 0);
        reset = 1'b0;

        // Nominal sweep, then outputs must hold
        sweep(3, 7, 0, 12, 5, 8'h00, 27, 12, 3, 1);
        drain();
        repeat (5) @(negedge clk);
        chk("hold_total", total, 27);

        // Tie resolved to the lowest channel
        sweep(9, 9, 2, 9, 1, 8'h00, 30, 9, 0, 1);
        drain();

        // Timeout on channel 2 only
        sweep(4, 4, 31, 4, 4, 8'h04, 16, 4, 0, 1);
        drain();

        // Every channel times out: worst-case length, all-zero max
        sweep(6, 6, 6, 6, 6, 8'h1f, 0, 0, 0, 1);
        drain();

        // Saturated counts
        sweep(31, 31, 31, 31, 31, 8'h00, 155, 31, 0, 1);
        drain();
        sweep(31, 1, 2, 3, 4, 8'h00, 41, 31, 0, 1);
        drain();

        // Reset mid-sweep at channel 3 discards the sweep
        sweep(20, 20, 20, 20, 20, 8'h00, 0, 0, 0, 0);
        n = 0;
        while (idx !== 3'd3 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("reach_idx3", idx, 3);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_rst_idx", idx, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_total", total, 0);
        chk("mid_rst_max", {max_idx, max_cnt}, 0);
        repeat (20) @(negedge clk);
        sweep(1, 2, 3, 4, 5, 8'h00, 15, 5, 4, 1);
        drain();

        // Reset and req together: reset wins
        @(negedge clk);
        reset = 1'b1;
        req   = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        req   = 1'b0;
        chk("rst_req_busy", busy, 0);
        @(negedge clk);
        chk("rst_req_busy2", busy, 0);

        // req pulsed while busy is ignored
        sweep(10, 20, 30, 1, 0, 8'h00, 61, 30, 2, 1);
        repeat (3) @(negedge clk);
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        drain();
        repeat (15) @(negedge clk);
        chk("ignored_req_busy", busy, 0);

        // req held high: back-to-back sweeps every 12 cycles
        @(negedge clk);
        load(2, 0, 8, 8, 1, 8'h00);
        req = 1'b1;
        st  = cyc + 1;
        push_exp(st, 19, 8, 2);
        push_exp(st + 12, 19, 8, 2);
        while (cyc < st + 12) @(negedge clk);
        req = 1'b0;
        drain();
        repeat (20) @(negedge clk);
        chk("after_held_busy", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
